// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO: depth/count sizing
// and the read-mode selector strings.
package sync_fifo_pkg;

  localparam logic [39:0] FT_TRUE  = "TRUE";
  localparam logic [39:0] FT_FALSE = "FALSE";

  function automatic int unsigned fifo_depth(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

  // The count must reach DEPTH, so it needs one bit more than the pointers.
  function automatic int unsigned count_width(input int unsigned addrsize);
    return addrsize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Single-clock simple dual-port storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module sync_fifo_ram #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  logic [DATASIZE-1:0] mem_q [2**ADDRSIZE];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count, almost thresholds, sticky error flags,
// synchronous flush and selectable fall-through or registered read.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATASIZE     = 8,
  parameter int unsigned ADDRSIZE     = 4,
  parameter logic [39:0] FALLTHROUGH  = FT_TRUE,
  parameter int unsigned AFULL_LEVEL  = fifo_depth(ADDRSIZE) - 2,
  parameter int unsigned AEMPTY_LEVEL = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [DATASIZE-1:0] wdata,
  output logic                full,
  output logic                almost_full,
  input  logic                rd_en,
  output logic [DATASIZE-1:0] rdata,
  output logic                empty,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  localparam int unsigned CW       = count_width(ADDRSIZE);
  localparam logic [CW-1:0] DEPTH_C  = CW'(fifo_depth(ADDRSIZE));
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);
  localparam bit FWFT = (FALLTHROUGH == FT_TRUE);

  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATASIZE-1:0] rdata_q, rdata_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic [DATASIZE-1:0] ram_rdata;
  logic                wr_acc, rd_acc;

  sync_fifo_ram #(
    .DATASIZE(DATASIZE),
    .ADDRSIZE(ADDRSIZE)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wptr_q),
    .wdata(wdata),
    .raddr(rptr_q),
    .rdata(ram_rdata)
  );

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign rdata        = FWFT ? ram_rdata : rdata_q;

  // Flush blocks both acceptances so the RAM write and pointers stay quiet.
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      rdata_d = '0;
    end else begin
      // Clear first so a same-cycle set takes precedence.
      if (clr_err) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      if (wr_en && full)  overflow_d  = 1'b1;
      if (rd_en && empty) underflow_d = 1'b1;
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) begin
        rptr_d  = rptr_q + 1'b1;
        rdata_d = ram_rdata;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a fall-through and a registered-read instance share
// stimulus and are checked against a queue-based reference model.
module tb_sync_fifo;

  logic       clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wdata = '0;

  logic [7:0] ft_rdata, rg_rdata;
  logic [4:0] ft_count, rg_count;
  logic ft_full, ft_af, ft_empty, ft_ae, ft_ovf, ft_udf;
  logic rg_full, rg_af, rg_empty, rg_ae, rg_ovf, rg_udf;
  logic [10:0] ft_stat, rg_stat;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit         m_ovf = 1'b0, m_udf = 1'b0;
  logic [7:0] m_rreg = '0;

  always #5 clk = ~clk;

  sync_fifo #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("TRUE"),
              .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut_ft (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wdata(wdata),
    .full(ft_full), .almost_full(ft_af), .rd_en(rd_en), .rdata(ft_rdata),
    .empty(ft_empty), .almost_empty(ft_ae), .count(ft_count),
    .overflow(ft_ovf), .underflow(ft_udf), .clr_err(clr_err));

  sync_fifo #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("FALSE"),
              .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut_rg (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wdata(wdata),
    .full(rg_full), .almost_full(rg_af), .rd_en(rd_en), .rdata(rg_rdata),
    .empty(rg_empty), .almost_empty(rg_ae), .count(rg_count),
    .overflow(rg_ovf), .underflow(rg_udf), .clr_err(clr_err));

  assign ft_stat = {ft_count, ft_full, ft_af, ft_empty, ft_ae, ft_ovf, ft_udf};
  assign rg_stat = {rg_count, rg_full, rg_af, rg_empty, rg_ae, rg_ovf, rg_udf};

  function automatic logic [10:0] exp_stat();
    int n;
    n = mq.size();
    return {5'(n), n == 16, n >= 14, n == 0, n <= 2, m_ovf, m_udf};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_rreg = '0;
  endtask

  // Apply the current inputs to the model, then advance one clock.
  task automatic step();
    bit is_full, is_empty;
    is_full  = (mq.size() == 16);
    is_empty = (mq.size() == 0);
    if (flush) begin
      mq.delete();
      m_rreg = '0;
    end else begin
      if (clr_err) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (wr_en && is_full)  m_ovf = 1'b1;
      if (rd_en && is_empty) m_udf = 1'b1;
      if (rd_en && !is_empty) m_rreg = mq.pop_front();
      if (wr_en && !is_full) mq.push_back(wdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ft_stat !== 11'b00000_0_0_1_1_0_0) begin
      errors++; $display("FAIL reset_ft_stat got %b exp %b", ft_stat, 11'b00000_0_0_1_1_0_0);
    end
    checks++;
    if (rg_stat !== 11'b00000_0_0_1_1_0_0) begin
      errors++; $display("FAIL reset_rg_stat got %b exp %b", rg_stat, 11'b00000_0_0_1_1_0_0);
    end
    checks++;
    if (rg_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rg_rdata got %h exp 00", rg_rdata);
    end
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wdata = 8'(i);
      step();
      checks++;
      if (ft_stat !== exp_stat()) begin
        errors++; $display("FAIL fill_stat[%0d] got %b exp %b", i, ft_stat, exp_stat());
      end
    end
    wdata = 8'hAA;
    step();
    idle();
    checks++;
    if (ft_stat !== exp_stat() || ft_ovf !== 1'b1 || ft_count !== 5'd16) begin
      errors++; $display("FAIL fill_overflow got %b exp %b", ft_stat, exp_stat());
    end
    checks++;
    if (rg_stat !== exp_stat()) begin
      errors++; $display("FAIL fill_rg_stat got %b exp %b", rg_stat, exp_stat());
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ft_rdata !== 8'(i)) begin
        errors++; $display("FAIL drain_ft_rdata[%0d] got %h exp %h", i, ft_rdata, 8'(i));
      end
      rd_en = 1'b1;
      step();
      checks++;
      if (ft_stat !== exp_stat() || rg_stat !== exp_stat()) begin
        errors++; $display("FAIL drain_stat[%0d] got %b/%b exp %b", i, ft_stat, rg_stat, exp_stat());
      end
      checks++;
      if (rg_rdata !== m_rreg) begin
        errors++; $display("FAIL drain_rg_rdata[%0d] got %h exp %h", i, rg_rdata, m_rreg);
      end
    end
    step();
    idle();
    checks++;
    if (ft_stat !== exp_stat() || ft_udf !== 1'b1 || ft_empty !== 1'b1) begin
      errors++; $display("FAIL drain_underflow got %b exp %b", ft_stat, exp_stat());
    end
  endtask

  task automatic test_clr_err();
    clr_err = 1'b1;
    step();
    idle();
    checks++;
    if (ft_stat !== exp_stat() || ft_ovf !== 1'b0 || ft_udf !== 1'b0) begin
      errors++; $display("FAIL clr_err got %b exp %b", ft_stat, exp_stat());
    end
  endtask

  task automatic test_reg_read();
    wr_en = 1'b1; wdata = 8'h5A;
    step();
    idle();
    checks++;
    if (rg_rdata !== m_rreg) begin
      errors++; $display("FAIL regread_before got %h exp %h", rg_rdata, m_rreg);
    end
    rd_en = 1'b1;
    step();
    idle();
    checks++;
    if (rg_rdata !== 8'h5A) begin
      errors++; $display("FAIL regread_data got %h exp 5a", rg_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rg_rdata !== 8'h5A) begin
        errors++; $display("FAIL regread_hold[%0d] got %h exp 5a", i, rg_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    while (mq.size() < 8) begin
      wr_en = 1'b1; wdata = 8'($urandom);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wdata = 8'($urandom);
      step();
      checks++;
      if (ft_stat !== exp_stat() || ft_count !== 5'd8) begin
        errors++; $display("FAIL b2b_stat[%0d] got %b exp %b", i, ft_stat, exp_stat());
      end
      checks++;
      if (ft_rdata !== mq[0] || rg_rdata !== m_rreg) begin
        errors++; $display("FAIL b2b_rdata[%0d] got %h/%h exp %h/%h", i, ft_rdata, rg_rdata, mq[0], m_rreg);
      end
    end
    idle();
  endtask

  task automatic test_flush();
    while (mq.size() > 5) begin
      rd_en = 1'b1;
      step();
    end
    idle();
    flush = 1'b1; wr_en = 1'b1; wdata = 8'($urandom);
    step();
    idle();
    checks++;
    if (ft_stat !== exp_stat() || ft_count !== 5'd0 || ft_empty !== 1'b1) begin
      errors++; $display("FAIL flush_stat got %b exp %b", ft_stat, exp_stat());
    end
    checks++;
    if (rg_rdata !== 8'h00 || rg_ovf !== 1'b0 || rg_udf !== 1'b0) begin
      errors++; $display("FAIL flush_rg got %h ovf %b udf %b exp 00 0 0", rg_rdata, rg_ovf, rg_udf);
    end
  endtask

  task automatic test_clr_vs_set();
    while (mq.size() < 16) begin
      wr_en = 1'b1; wdata = 8'($urandom);
      step();
    end
    clr_err = 1'b1;
    step();
    idle();
    checks++;
    if (ft_ovf !== 1'b1 || ft_stat !== exp_stat()) begin
      errors++; $display("FAIL clr_vs_set got ovf %b exp 1", ft_ovf);
    end
    clr_err = 1'b1;
    step();
    idle();
    checks++;
    if (ft_ovf !== 1'b0 || rg_ovf !== 1'b0 || ft_stat !== exp_stat()) begin
      errors++; $display("FAIL clr_alone got ovf %b/%b exp 0", ft_ovf, rg_ovf);
    end
  endtask

  task automatic test_async_reset();
    flush = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wdata = 8'($urandom);
      step();
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ft_count !== 5'd0 || ft_empty !== 1'b1 || rg_count !== 5'd0 || rg_empty !== 1'b1) begin
      errors++; $display("FAIL async_reset got count %0d empty %b exp 0 1", ft_count, ft_empty);
    end
    model_reset();
    idle();
    @(posedge clk);
    #1 reset = 1'b1;
    checks++;
    if (ft_stat !== exp_stat() || rg_rdata !== 8'h00) begin
      errors++; $display("FAIL async_reset_hold got %b exp %b", ft_stat, exp_stat());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 99) < 55);
      rd_en   = ($urandom_range(0, 99) < 50);
      flush   = ($urandom_range(0, 99) < 3);
      clr_err = ($urandom_range(0, 99) < 5);
      wdata   = 8'($urandom);
      step();
      checks++;
      if (ft_stat !== exp_stat() || rg_stat !== exp_stat()) begin
        errors++; $display("FAIL rand_stat[%0d] got %b/%b exp %b", i, ft_stat, rg_stat, exp_stat());
      end
      checks++;
      if (rg_rdata !== m_rreg) begin
        errors++; $display("FAIL rand_rg_rdata[%0d] got %h exp %h", i, rg_rdata, m_rreg);
      end
      if (mq.size() != 0) begin
        checks++;
        if (ft_rdata !== mq[0]) begin
          errors++; $display("FAIL rand_ft_rdata[%0d] got %h exp %h", i, ft_rdata, mq[0]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_clr_err();
    test_reg_read();
    test_back_to_back();
    test_flush();
    test_clr_vs_set();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
